shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier_pkg.sv | 16 +
 rtl/shift_add_multiplier_adder.sv | 28 ++
 rtl/shift_add_multiplier.sv | 106 ++++++++++
 tb/tb_shift_add_multiplier.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encodings
// and the width helper for the iteration counter.
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mult_state_t;

    // Counter width: ceil(log2 n) + 1 bits, so the count n-1 always fits
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// Ripple-carry adder, (n+1) bits wide. The output is one bit wider than the
// operands so the carry out of the top bit is kept in total_sum[n+1].
module shift_add_multiplier_adder #(
    parameter int n = 7
) (
    input  logic [n:0]   a,
    input  logic [n:0]   b,
    input  logic         carry_in,
    output logic [n+1:0] total_sum
);

    logic [n+1:0] carry;
    logic [n:0]   sum_bits;

    // Bit-serial full-adder chain from LSB to MSB
    always_comb begin
        carry    = '0;
        sum_bits = '0;
        carry[0] = carry_in;
        for (int i = 0; i <= n; i++) begin
            sum_bits[i]  = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
        end
    end

    assign total_sum = {carry[n + 1], sum_bits};

endmodule

// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned N x N multiplier. One add-and-shift per clock through
// a single ripple-carry adder; registered 2N-bit product and a one-cycle done.
// Handshake: start is sampled only while idle (busy low); once accepted, a/b
// are captured and further start pulses are ignored until busy drops. done is
// high for exactly one cycle, and product is valid from that cycle until the
// next completion.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic [1:0]     dbg_state
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    mult_state_t    state_q;
    mult_state_t    state_d;
    logic [N-1:0]   mcand;
    logic [N-1:0]   hi;
    logic [N-1:0]   lo;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] prod_q;
    logic [N-1:0]   add_b;
    logic [N:0]     sum;
    logic           last_step;

    // Partial-product addend: multiplicand when the current multiplier bit is set
    assign add_b     = lo[0] ? mcand : '0;
    assign last_step = (cnt == CNT_LAST);

    shift_add_multiplier_adder #(
        .n (N - 1)
    ) u_adder (
        .a         (hi),
        .b         (add_b),
        .carry_in  (1'b0),
        .total_sum (sum)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the unused encoding falls back to idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last_step) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, add-and-shift, final product capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            prod_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mcand <= a;
                        hi    <= '0;
                        lo    <= b;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    hi  <= sum[N:1];
                    lo  <= {sum[0], lo[N-1:1]};
                    cnt <= cnt + CW'(1);
                    if (last_step) begin
                        prod_q <= {sum[N:1], sum[0], lo[N-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign product   = prod_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

    logic        clk;
    logic        rst;

    logic        start8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] prod8;
    logic [1:0]  st8;

    logic        start4;
    logic [3:0]  a4, b4;
    logic        busy4, done4;
    logic [7:0]  prod4;
    logic [1:0]  st4;

    int n_checks;
    int n_pass;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[7];

    shift_add_multiplier #(.N(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start8),
        .a         (a8),
        .b         (b8),
        .busy      (busy8),
        .done      (done8),
        .product   (prod8),
        .dbg_state (st8)
    );

    shift_add_multiplier #(.N(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .start     (start4),
        .a         (a4),
        .b         (b4),
        .busy      (busy4),
        .done      (done4),
        .product   (prod4),
        .dbg_state (st4)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Wait (bounded) until dut8 is idle; returns 1 if it became idle
    task automatic wait_idle8(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy8) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One-cycle start pulse on dut8; reports latency (edges from accept to
    // done visible, -1 on timeout), product in the done cycle and
    // {busy,done} one cycle after done.
    task automatic run_op8(input logic [7:0] x, input logic [7:0] y,
                           output logic [15:0] p, output int lat, output logic [1:0] tail);
        bit ok;
        wait_idle8(ok);
        a8 = x;
        b8 = y;
        start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        lat = -1;
        p = '0;
        tail = 2'b11;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done8) begin
                lat = k;
                p = prod8;
                break;
            end
        end
        if (lat > 0) begin
            @(negedge clk);
            tail = {busy8, done8};
        end
    endtask

    task automatic run_op4(input logic [3:0] x, input logic [3:0] y,
                           output logic [7:0] p, output int lat);
        for (int i = 0; i < 20; i++) begin
            if (!busy4) break;
            @(negedge clk);
        end
        a4 = x;
        b4 = y;
        start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        lat = -1;
        p = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done4) begin
                lat = k;
                p = prod4;
                break;
            end
        end
    endtask

    initial begin
        logic [15:0] p;
        logic [7:0]  p4;
        logic [1:0]  tail;
        int          lat;
        int          seen;
        int          cyc;
        int          done_cyc[$];
        logic [15:0] done_prod[$];
        logic [15:0] exp_q[$];
        logic [7:0]  ra, rb;
        bit          ok;
        int          bad4;

        n_checks = 0;
        n_pass   = 0;

        tbl[0] = '{a: 8'd13,  b: 8'd11,  exp: 16'h008F};
        tbl[1] = '{a: 8'd255, b: 8'd255, exp: 16'hFE01};
        tbl[2] = '{a: 8'd0,   b: 8'd200, exp: 16'h0000};
        tbl[3] = '{a: 8'd1,   b: 8'd1,   exp: 16'h0001};
        tbl[4] = '{a: 8'd255, b: 8'd1,   exp: 16'h00FF};
        tbl[5] = '{a: 8'd128, b: 8'd2,   exp: 16'h0100};
        tbl[6] = '{a: 8'd200, b: 8'd0,   exp: 16'h0000};

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        #1;
        check("reset_busy", {31'd0, busy8}, 32'd0);
        check("reset_done", {31'd0, done8}, 32'd0);
        check("reset_product", {16'd0, prod8}, 32'd0);
        check("reset_product4", {24'd0, prod4}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors: product, latency N, idle one cycle after done
        for (int i = 0; i < 7; i++) begin
            run_op8(tbl[i].a, tbl[i].b, p, lat, tail);
            check($sformatf("tbl%0d_product", i), {16'd0, p}, {16'd0, tbl[i].exp});
            check($sformatf("tbl%0d_latency", i), lat, 32'd8);
            check($sformatf("tbl%0d_tail", i), {30'd0, tail}, 32'd0);
        end

        // start during RUN is ignored
        wait_idle8(ok);
        a8 = 8'd3; b8 = 8'd5; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'd7; b8 = 8'd7; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        p = '0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done8) begin
                p = prod8;
                seen = 1;
                break;
            end
        end
        check("ignore_start_done_seen", seen, 32'd1);
        check("ignore_start_product", {16'd0, p}, 32'd15);
        seen = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (done8) seen++;
        end
        check("ignore_start_no_second_done", seen, 32'd0);
        check("ignore_start_product_held", {16'd0, prod8}, 32'd15);
        check("ignore_start_idle", {31'd0, busy8}, 32'd0);

        // Asynchronous reset mid-operation
        wait_idle8(ok);
        a8 = 8'd100; b8 = 8'd100; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_done", {31'd0, done8}, 32'd0);
        check("abort_product", {16'd0, prod8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (done8) seen++;
        end
        check("abort_no_done", seen, 32'd0);
        run_op8(8'd2, 8'd3, p, lat, tail);
        check("after_abort_product", {16'd0, p}, 32'd6);
        check("after_abort_latency", lat, 32'd8);

        // start held high: back-to-back operations every N+2 cycles
        wait_idle8(ok);
        a8 = 8'd6; b8 = 8'd7; start8 = 1'b1;
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                a8 = 8'd9;
                b8 = 8'd9;
            end
            if (done8) begin
                done_cyc.push_back(cyc);
                done_prod.push_back(prod8);
                if (done_cyc.size() == 2) begin
                    start8 = 1'b0;
                    break;
                end
            end
        end
        start8 = 1'b0;
        check("b2b_done_count", done_cyc.size(), 32'd2);
        if (done_cyc.size() == 2) begin
            check("b2b_spacing", done_cyc[1] - done_cyc[0], 32'd10);
            check("b2b_first_latency", done_cyc[0], 32'd9);
            check("b2b_product0", {16'd0, done_prod[0]}, 32'd42);
            check("b2b_product1", {16'd0, done_prod[1]}, 32'd81);
        end
        wait_idle8(ok);
        check("b2b_returns_idle", {31'd0, ok}, 32'd1);

        // Random N=8 operations against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            exp_q.push_back(16'(ra) * 16'(rb));
            run_op8(ra, rb, p, lat, tail);
            check($sformatf("rand%0d_%0dx%0d", i, ra, rb), {16'd0, p}, {16'd0, exp_q.pop_front()});
        end

        // N=4 exhaustive
        bad4 = 0;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                run_op4(4'(x), 4'(y), p4, lat);
                check($sformatf("n4_%0dx%0d", x, y), {24'd0, p4}, 32'(x * y));
                if (lat != 4) bad4++;
            end
        end
        check("n4_latency_all", bad4, 32'd0);
        check("n4_max_held", {24'd0, prod4}, 32'hE1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
